perf_counter_display: RTL and testbench

- Downstream consumer of the performance counter block.
- Takes the four 32-bit statistics (total cycles, conditional branches, unconditional jumps, successful conditional branches) and shows one of them on an 8-digit multiplexed 7-segment display.
- A debounced board button cycles the selected counter.
- The shown value is snapshotted once per display frame to prevent digit tearing.

---
 rtl/perf_display_pkg.sv | 19 +
 rtl/perf_bcd_conv.sv | 61 ++++++
 rtl/perf_counter_display.sv | 169 ++++++++++++++++
 tb/tb_perf_counter_display.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/perf_display_pkg.sv
// rtl/perf_display_pkg.sv - shared types, digit count and hex segment table for perf_counter_display
package perf_display_pkg;

    typedef enum logic [1:0] {
        SEL_TOTAL   = 2'd0,
        SEL_COND    = 2'd1,
        SEL_UNCOND  = 2'd2,
        SEL_COND_OK = 2'd3
    } sel_t;

    localparam int NUM_DIGITS = 8;

    // Active-low {g,f,e,d,c,b,a} patterns for 0..F
    localparam logic [6:0] HEX_SEG [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/perf_bcd_conv.sv
// rtl/perf_bcd_conv.sv - sequential 32-bit double-dabble converter (start/busy/done)
module perf_bcd_conv (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] value,
    output logic        done,
    output logic [31:0] bcd,
    output logic        overflow
);

    logic        busy;
    logic [4:0]  cnt;
    logic [31:0] bin;
    logic [39:0] work;
    logic [39:0] adj;
    logic [71:0] shifted;

    // Add-3 correction on every BCD digit >= 5, then shift the combined register left
    always_comb begin
        adj = work;
        for (int i = 0; i < 10; i++) begin
            if (work[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
            end
        end
        shifted = {adj[38:0], bin, 1'b0};
    end

    // One shift per cycle for 32 cycles; a new start always restarts from scratch
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
            cnt  <= '0;
            bin  <= '0;
            work <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                busy <= 1'b1;
                cnt  <= '0;
                bin  <= value;
                work <= '0;
            end else if (busy) begin
                bin  <= shifted[31:0];
                work <= shifted[71:32];
                cnt  <= cnt + 5'd1;
                if (cnt == 5'd31) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    // Low 8 decimal digits; anything in the top two digits means >= 100000000
    assign bcd      = work[31:0];
    assign overflow = |work[39:32];

endmodule

// File: rtl/perf_counter_display.sv
// rtl/perf_counter_display.sv - 8-digit 7-segment viewer for perf counters; PERF_DISPLAY_BCD_EN selects decimal output
module perf_counter_display
    import perf_display_pkg::*;
#(
    parameter int REFRESH_DIV     = 100000,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] total,
    input  logic [31:0] conditional,
    input  logic [31:0] unconditional,
    input  logic [31:0] conditional_success,
    input  logic        sel_btn,
    input  logic        freeze,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  mode_led
);

    localparam int DIV_W = $clog2(REFRESH_DIV);
    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             btn_meta;
    logic             btn_sync;
    logic             btn_level;
    logic [DEB_W-1:0] deb_cnt;
    sel_t             sel;
    logic             sel_changed;
    logic [DIV_W-1:0] div;
    logic [2:0]       idx;
    logic [31:0]      snapshot;
    logic [31:0]      selected;
    logic [31:0]      disp_value;
    logic             overflow;
    logic             div_end;
    logic             frame_end;
    logic             load;

    // Two-flop synchroniser for the asynchronous button
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            btn_meta <= sel_btn;
            btn_sync <= btn_meta;
        end
    end

    // Accept a new level only after DEBOUNCE_CYCLES differing samples in a row; a press advances sel
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_level   <= 1'b0;
            deb_cnt     <= '0;
            sel         <= SEL_TOTAL;
            sel_changed <= 1'b0;
        end else begin
            sel_changed <= 1'b0;
            if (btn_sync == btn_level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                deb_cnt   <= '0;
                btn_level <= btn_sync;
                if (btn_sync) begin
                    sel         <= sel_t'(sel + 2'd1);
                    sel_changed <= 1'b1;
                end
            end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
        end
    end

    // Counter selected for the next snapshot
    always_comb begin
        selected = total;
        case (sel)
            SEL_TOTAL:   selected = total;
            SEL_COND:    selected = conditional;
            SEL_UNCOND:  selected = unconditional;
            SEL_COND_OK: selected = conditional_success;
            default:     selected = total;
        endcase
    end

    assign div_end   = (div == DIV_W'(REFRESH_DIV - 1));
    assign frame_end = div_end && (idx == 3'(NUM_DIGITS - 1));
    assign load      = sel_changed || (frame_end && !freeze);

    // Digit scan: each digit stays lit for REFRESH_DIV cycles, scanning 0..7
    always_ff @(posedge clk) begin
        if (rst) begin
            div <= '0;
            idx <= '0;
        end else if (div_end) begin
            div <= '0;
            idx <= idx + 3'd1;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    // Snapshot at frame start so a frame never mixes old and new digits; a sel change loads immediately
    always_ff @(posedge clk) begin
        if (rst) begin
            snapshot <= '0;
        end else if (load) begin
            snapshot <= selected;
        end
    end

`ifdef PERF_DISPLAY_BCD_EN
    logic        bcd_start;
    logic        bcd_done;
    logic        bcd_ovf;
    logic [31:0] bcd_digits;
    logic [31:0] shown_bcd;
    logic        shown_ovf;

    perf_bcd_conv u_bcd (
        .clk      (clk),
        .rst      (rst),
        .start    (bcd_start),
        .value    (snapshot),
        .done     (bcd_done),
        .bcd      (bcd_digits),
        .overflow (bcd_ovf)
    );

    // Convert the snapshot once it settles; keep showing the last finished result meanwhile
    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_start <= 1'b0;
            shown_bcd <= '0;
            shown_ovf <= 1'b0;
        end else begin
            bcd_start <= load;
            if (bcd_done) begin
                shown_bcd <= bcd_digits;
                shown_ovf <= bcd_ovf;
            end
        end
    end

    assign disp_value = shown_bcd;
    assign overflow   = shown_ovf;
`else
    assign disp_value = snapshot;
    assign overflow   = 1'b0;
`endif

    // Registered digit drive, one cycle behind idx
    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= 8'hFE;
            seg <= 7'h40;
            dp  <= 1'b1;
        end else begin
            an  <= ~(8'b1 << idx);
            seg <= HEX_SEG[disp_value[{idx, 2'b00} +: 4]];
            dp  <= !(((idx == 3'd0) && freeze) || ((idx == 3'd7) && overflow));
        end
    end

    assign mode_led = 4'b0001 << sel;

endmodule

// File: tb/tb_perf_counter_display.sv
// tb/tb_perf_counter_display.sv - directed self-checking bench for perf_counter_display
module tb_perf_counter_display;

`ifdef PERF_DISPLAY_BCD_EN
    localparam int CONV_WAIT = 40;
`else
    localparam int CONV_WAIT = 0;
`endif
    localparam int SETTLE = 40 + CONV_WAIT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] total = '0;
    logic [31:0] conditional = '0;
    logic [31:0] unconditional = '0;
    logic [31:0] conditional_success = '0;
    logic        sel_btn = 1'b0;
    logic        freeze = 1'b0;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  mode_led;

    int n_pass  = 0;
    int n_total = 0;

    perf_counter_display #(
        .REFRESH_DIV     (4),
        .DEBOUNCE_CYCLES (3)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .total               (total),
        .conditional         (conditional),
        .unconditional       (unconditional),
        .conditional_success (conditional_success),
        .sel_btn             (sel_btn),
        .freeze              (freeze),
        .an                  (an),
        .seg                 (seg),
        .dp                  (dp),
        .mode_led            (mode_led)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [3:0] exp_digit(input logic [31:0] v, input int k);
        logic [31:0] t;
        t = v;
`ifdef PERF_DISPLAY_BCD_EN
        for (int i = 0; i < k; i++) t = t / 10;
        return 4'(t % 10);
`else
        return 4'(t >> (4 * k));
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns on the first cycle digit 0 is lit, or after 40 cycles
    task automatic wait_digit0();
        logic [7:0] prev;
        prev = an;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (prev !== 8'hFE && an === 8'hFE) return;
            prev = an;
        end
    endtask

    task automatic press(input int hold);
        sel_btn = 1'b1;
        repeat (hold) tick();
        sel_btn = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_total++; if (an !== 8'hFE) $display("FAIL reset_an: got %h want %h", an, 8'hFE); else n_pass++;
        n_total++; if (seg !== 7'h40) $display("FAIL reset_seg: got %h want %h", seg, 7'h40); else n_pass++;
        n_total++; if (dp !== 1'b1) $display("FAIL reset_dp: got %b want 1", dp); else n_pass++;
        n_total++; if (mode_led !== 4'b0001) $display("FAIL reset_mode_led: got %b want 0001", mode_led); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_hex_display();
        logic [7:0] prev;
        bit found;
        logic [7:0] want_an;
        logic [6:0] want_seg;
        total = 32'h12345678;
        repeat (SETTLE) tick();
        found = 1'b0;
        prev = an;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            if (prev === 8'h7F && an === 8'hFE) found = 1'b1;
            else prev = an;
        end
        n_total++; if (!found) $display("FAIL hex_frame_sync: got no 7F->FE transition want one"); else n_pass++;
        for (int k = 0; k < 32; k++) begin
            want_an  = ~(8'b1 << (k / 4));
            want_seg = seg_of(exp_digit(32'h12345678, k / 4));
            n_total++; if (an !== want_an) $display("FAIL hex_an[%0d]: got %h want %h", k, an, want_an); else n_pass++;
            n_total++; if (seg !== want_seg) $display("FAIL hex_seg[%0d]: got %h want %h", k, seg, want_seg); else n_pass++;
            tick();
        end
    endtask

    task automatic test_debounce();
        sel_btn = 1'b1;
        tick();
        tick();
        sel_btn = 1'b0;
        repeat (10) tick();
        n_total++; if (mode_led !== 4'b0001) $display("FAIL glitch_ignored: got %b want 0001", mode_led); else n_pass++;
        press(10);
        n_total++; if (mode_led !== 4'b0010) $display("FAIL press_once: got %b want 0010", mode_led); else n_pass++;
        press(10);
        n_total++; if (mode_led !== 4'b0100) $display("FAIL press_two: got %b want 0100", mode_led); else n_pass++;
        press(10);
        n_total++; if (mode_led !== 4'b1000) $display("FAIL press_three: got %b want 1000", mode_led); else n_pass++;
        press(10);
        n_total++; if (mode_led !== 4'b0001) $display("FAIL press_wrap: got %b want 0001", mode_led); else n_pass++;
    endtask

    task automatic test_freeze();
        total  = 32'hA;
        freeze = 1'b0;
        repeat (SETTLE) tick();
        wait_digit0();
        n_total++; if (seg !== seg_of(exp_digit(32'hA, 0))) $display("FAIL freeze_pre_seg: got %h want %h", seg, seg_of(exp_digit(32'hA, 0))); else n_pass++;
        freeze = 1'b1;
        total  = 32'hB;
        repeat (96) tick();
        wait_digit0();
        n_total++; if (an !== 8'hFE) $display("FAIL freeze_digit0_an: got %h want %h", an, 8'hFE); else n_pass++;
        n_total++; if (seg !== seg_of(exp_digit(32'hA, 0))) $display("FAIL freeze_hold_seg: got %h want %h", seg, seg_of(exp_digit(32'hA, 0))); else n_pass++;
        n_total++; if (dp !== 1'b0) $display("FAIL freeze_dp0_lit: got %b want 0", dp); else n_pass++;
        repeat (4) tick();
        n_total++; if (an !== 8'hFD) $display("FAIL freeze_digit1_an: got %h want %h", an, 8'hFD); else n_pass++;
        n_total++; if (dp !== 1'b1) $display("FAIL freeze_dp1_unlit: got %b want 1", dp); else n_pass++;
        freeze = 1'b0;
        repeat (SETTLE) tick();
        wait_digit0();
        n_total++; if (seg !== seg_of(exp_digit(32'hB, 0))) $display("FAIL unfreeze_seg: got %h want %h", seg, seg_of(exp_digit(32'hB, 0))); else n_pass++;
        n_total++; if (dp !== 1'b1) $display("FAIL unfreeze_dp: got %b want 1", dp); else n_pass++;
    endtask

    task automatic test_sel_while_frozen();
        freeze        = 1'b1;
        conditional   = 32'h3;
        unconditional = 32'h7;
        press(10);
        repeat (CONV_WAIT) tick();
        wait_digit0();
        n_total++; if (mode_led !== 4'b0010) $display("FAIL frozen_sel1_led: got %b want 0010", mode_led); else n_pass++;
        n_total++; if (seg !== seg_of(exp_digit(32'h3, 0))) $display("FAIL frozen_sel1_seg: got %h want %h", seg, seg_of(exp_digit(32'h3, 0))); else n_pass++;
        press(10);
        repeat (CONV_WAIT) tick();
        wait_digit0();
        n_total++; if (mode_led !== 4'b0100) $display("FAIL frozen_sel2_led: got %b want 0100", mode_led); else n_pass++;
        n_total++; if (seg !== seg_of(exp_digit(32'h7, 0))) $display("FAIL frozen_sel2_seg: got %h want %h", seg, seg_of(exp_digit(32'h7, 0))); else n_pass++;
        n_total++; if (dp !== 1'b0) $display("FAIL frozen_sel2_dp: got %b want 0", dp); else n_pass++;
        unconditional = 32'h9;
        repeat (70) tick();
        wait_digit0();
        n_total++; if (seg !== seg_of(exp_digit(32'h7, 0))) $display("FAIL frozen_sel2_hold: got %h want %h", seg, seg_of(exp_digit(32'h7, 0))); else n_pass++;
        freeze = 1'b0;
    endtask

`ifdef PERF_DISPLAY_BCD_EN
    task automatic test_bcd();
        logic [6:0] want_seg [8];
        logic [7:0] want_an;
        press(10);
        press(10);
        n_total++; if (mode_led !== 4'b0001) $display("FAIL bcd_sel_total: got %b want 0001", mode_led); else n_pass++;
        want_seg = '{7'h02, 7'h10, 7'h00, 7'h10, 7'h79, 7'h19, 7'h12, 7'h40};
        total = 32'd305419896;
        repeat (80) tick();
        wait_digit0();
        for (int d = 0; d < 8; d++) begin
            want_an = ~(8'b1 << d);
            n_total++; if (an !== want_an) $display("FAIL bcd_an[%0d]: got %h want %h", d, an, want_an); else n_pass++;
            n_total++; if (seg !== want_seg[d]) $display("FAIL bcd_seg[%0d]: got %h want %h", d, seg, want_seg[d]); else n_pass++;
            if (d == 7) begin
                n_total++; if (dp !== 1'b0) $display("FAIL bcd_ovf_dp: got %b want 0", dp); else n_pass++;
            end
            repeat (4) tick();
        end
        total = 32'd99;
        repeat (80) tick();
        wait_digit0();
        n_total++; if (seg !== 7'h10) $display("FAIL bcd99_d0: got %h want %h", seg, 7'h10); else n_pass++;
        repeat (4) tick();
        n_total++; if (seg !== 7'h10) $display("FAIL bcd99_d1: got %h want %h", seg, 7'h10); else n_pass++;
        repeat (4) tick();
        n_total++; if (seg !== 7'h40) $display("FAIL bcd99_d2: got %h want %h", seg, 7'h40); else n_pass++;
        repeat (20) tick();
        n_total++; if (an !== 8'h7F) $display("FAIL bcd99_d7_an: got %h want %h", an, 8'h7F); else n_pass++;
        n_total++; if (dp !== 1'b1) $display("FAIL bcd99_dp: got %b want 1", dp); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_hex_display();
        test_debounce();
        test_freeze();
        test_sel_while_frozen();
`ifdef PERF_DISPLAY_BCD_EN
        test_bcd();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
